// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths, FSM encoding, held-instruction layout and RF address formatting
// for the operand fetch stage.
package operand_fetch_stage_pkg;

    localparam int DATA_W       = 16;
    localparam int N_BLOCKS     = 256;
    localparam int N_BLOCK_REGS = 2;
    localparam int BW           = $clog2(N_BLOCKS);
    localparam int RW           = $clog2(N_BLOCK_REGS);
    localparam int CTRL_W       = 38;
    localparam int RF_AW        = 1 + BW + RW;
    localparam int N_CH         = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_READ  = 2'd2,
        ST_VALID = 2'd3
    } ofs_state_e;

    // Index 0/1/2 of the per-operand fields correspond to operands a/b/c.
    typedef struct packed {
        logic [BW-1:0]     block;
        logic [4:0]        operation;
        logic [2:0][3:0]   src;
        logic [2:0]        src_reg;
        logic [2:0]        needed;
        logic              acc_needed;
        logic [3:0]        dest;
        logic              writes_ch;
        logic              writes_acc;
        logic [CTRL_W-1:0] ctrl;
    } instr_t;

    function automatic logic [RF_AW-1:0] rf_addr_f(input logic          is_blk,
                                                   input logic [BW-1:0] block,
                                                   input logic [3:0]    src);
        if (is_blk) return {1'b1, block, src[RW-1:0]};
        return {1'b0, {(BW + RW - 4){1'b0}}, src};
    endfunction

endpackage

// File: rtl/operand_fetch_stage_op_scoreboard.sv
// Pending-write scoreboard: one bit per channel register plus the accumulator.
// Retirement clears are taken regardless of stage enable; a same-bit set wins.
module operand_fetch_stage_op_scoreboard
    import operand_fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            set_en_i,
    input  logic            set_ch_i,
    input  logic [3:0]      set_dest_i,
    input  logic            set_acc_i,
    input  logic            clr_en_i,
    input  logic            clr_ch_i,
    input  logic [3:0]      clr_dest_i,
    input  logic            clr_acc_i,
    input  logic [N_CH-1:0] chk_ch_mask_i,
    input  logic            chk_acc_i,
    output logic            hazard_o
);

    logic [N_CH-1:0] ch_pend_q, ch_pend_d;
    logic            acc_pend_q, acc_pend_d;

    always_comb begin
        ch_pend_d  = ch_pend_q;
        acc_pend_d = acc_pend_q;
        if (clr_en_i && clr_ch_i)  ch_pend_d[clr_dest_i] = 1'b0;
        if (clr_en_i && clr_acc_i) acc_pend_d = 1'b0;
        if (set_en_i && set_ch_i)  ch_pend_d[set_dest_i] = 1'b1;
        if (set_en_i && set_acc_i) acc_pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_pend_q  <= '0;
            acc_pend_q <= 1'b0;
        end else begin
            ch_pend_q  <= ch_pend_d;
            acc_pend_q <= acc_pend_d;
        end
    end

    assign hazard_o = (|(ch_pend_q & chk_ch_mask_i)) | (chk_acc_i & acc_pend_q);

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: accepts a decoded instruction, stalls on RAW/WAW against the
// scoreboard, reads up to three operands from the sync-read RF and presents them to execute.
//
// state  | meaning
// IDLE   | no instruction held, ready to accept
// CHECK  | instruction held, RF addresses driven, waiting for hazard to clear
// READ   | RF read in flight, scoreboard already marked for this instruction
// VALID  | instruction + operands presented to execute
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BW-1:0]     in_block,
    input  logic [4:0]        in_operation,
    input  logic [3:0]        in_src_a,
    input  logic [3:0]        in_src_b,
    input  logic [3:0]        in_src_c,
    input  logic              in_src_a_reg,
    input  logic              in_src_b_reg,
    input  logic              in_src_c_reg,
    input  logic              in_arg_a_needed,
    input  logic              in_arg_b_needed,
    input  logic              in_arg_c_needed,
    input  logic              in_acc_needed,
    input  logic [3:0]        in_dest,
    input  logic              in_writes_ch,
    input  logic              in_writes_acc,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [RF_AW-1:0]  rf_addr_a,
    output logic [RF_AW-1:0]  rf_addr_b,
    output logic [RF_AW-1:0]  rf_addr_c,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b,
    input  logic [DATA_W-1:0] rf_data_c,
    input  logic              wb_valid,
    input  logic              wb_ch,
    input  logic              wb_acc,
    input  logic [3:0]        wb_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BW-1:0]     out_block,
    output logic [4:0]        out_operation,
    output logic [3:0]        out_dest,
    output logic              out_writes_ch,
    output logic              out_writes_acc,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_acc_needed,
    output logic [DATA_W-1:0] out_op_a,
    output logic [DATA_W-1:0] out_op_b,
    output logic [DATA_W-1:0] out_op_c
);

    ofs_state_e        state_q, state_d;
    instr_t            hold_q, hold_d;
    instr_t            in_instr;
    logic              out_valid_q, out_valid_d;
    logic              out_load;
    logic              set_en;
    logic              hazard;
    logic [N_CH-1:0]   chk_ch_mask;
    logic [DATA_W-1:0] rf_data [3];

    logic [BW-1:0]     out_block_q;
    logic [4:0]        out_operation_q;
    logic [3:0]        out_dest_q;
    logic              out_writes_ch_q;
    logic              out_writes_acc_q;
    logic [CTRL_W-1:0] out_ctrl_q;
    logic              out_acc_needed_q;
    logic [DATA_W-1:0] out_op_q [3];

    always_comb begin
        in_instr            = '0;
        in_instr.block      = in_block;
        in_instr.operation  = in_operation;
        in_instr.src[0]     = in_src_a;
        in_instr.src[1]     = in_src_b;
        in_instr.src[2]     = in_src_c;
        in_instr.src_reg    = {in_src_c_reg, in_src_b_reg, in_src_a_reg};
        in_instr.needed     = {in_arg_c_needed, in_arg_b_needed, in_arg_a_needed};
        in_instr.acc_needed = in_acc_needed;
        in_instr.dest       = in_dest;
        in_instr.writes_ch  = in_writes_ch;
        in_instr.writes_acc = in_writes_acc;
        in_instr.ctrl       = in_ctrl;
    end

    // Block-register sources are block-private and never enter the hazard mask.
    always_comb begin
        chk_ch_mask = '0;
        for (int i = 0; i < 3; i++) begin
            if (hold_q.needed[i] && !hold_q.src_reg[i]) chk_ch_mask[hold_q.src[i]] = 1'b1;
        end
        if (hold_q.writes_ch) chk_ch_mask[hold_q.dest] = 1'b1;
    end

    operand_fetch_stage_op_scoreboard u_sb (
        .clk           (clk),
        .reset         (reset),
        .set_en_i      (set_en),
        .set_ch_i      (hold_q.writes_ch),
        .set_dest_i    (hold_q.dest),
        .set_acc_i     (hold_q.writes_acc),
        .clr_en_i      (wb_valid),
        .clr_ch_i      (wb_ch),
        .clr_dest_i    (wb_dest),
        .clr_acc_i     (wb_acc),
        .chk_ch_mask_i (chk_ch_mask),
        .chk_acc_i     (hold_q.acc_needed | hold_q.writes_acc),
        .hazard_o      (hazard)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        out_load    = 1'b0;
        set_en      = 1'b0;
        in_ready    = enable && ((state_q == ST_IDLE) || ((state_q == ST_VALID) && out_ready));
        if (enable) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        hold_d  = in_instr;
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!hazard) begin
                        set_en  = 1'b1;
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    out_load    = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = ST_VALID;
                end
                ST_VALID: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (in_valid) begin
                            hold_d  = in_instr;
                            state_d = ST_CHECK;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign rf_data[0] = rf_data_a;
    assign rf_data[1] = rf_data_b;
    assign rf_data[2] = rf_data_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            hold_q           <= '0;
            out_valid_q      <= 1'b0;
            out_block_q      <= '0;
            out_operation_q  <= '0;
            out_dest_q       <= '0;
            out_writes_ch_q  <= 1'b0;
            out_writes_acc_q <= 1'b0;
            out_ctrl_q       <= '0;
            out_acc_needed_q <= 1'b0;
            for (int i = 0; i < 3; i++) out_op_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            if (out_load) begin
                out_block_q      <= hold_q.block;
                out_operation_q  <= hold_q.operation;
                out_dest_q       <= hold_q.dest;
                out_writes_ch_q  <= hold_q.writes_ch;
                out_writes_acc_q <= hold_q.writes_acc;
                out_ctrl_q       <= hold_q.ctrl;
                out_acc_needed_q <= hold_q.acc_needed;
                for (int i = 0; i < 3; i++)
                    out_op_q[i] <= hold_q.needed[i] ? rf_data[i] : '0;
            end
        end
    end

    assign rf_addr_a = rf_addr_f(hold_q.src_reg[0], hold_q.block, hold_q.src[0]);
    assign rf_addr_b = rf_addr_f(hold_q.src_reg[1], hold_q.block, hold_q.src[1]);
    assign rf_addr_c = rf_addr_f(hold_q.src_reg[2], hold_q.block, hold_q.src[2]);

    assign out_valid      = out_valid_q;
    assign out_block      = out_block_q;
    assign out_operation  = out_operation_q;
    assign out_dest       = out_dest_q;
    assign out_writes_ch  = out_writes_ch_q;
    assign out_writes_acc = out_writes_acc_q;
    assign out_ctrl       = out_ctrl_q;
    assign out_acc_needed = out_acc_needed_q;
    assign out_op_a       = out_op_q[0];
    assign out_op_b       = out_op_q[1];
    assign out_op_c       = out_op_q[2];

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a sync-read register file model.
module tb_operand_fetch_stage;
    import operand_fetch_stage_pkg::*;

    logic              clk = 1'b0;
    logic              reset, enable, in_valid, in_ready;
    logic [BW-1:0]     in_block;
    logic [4:0]        in_operation;
    logic [3:0]        in_src_a, in_src_b, in_src_c;
    logic              in_src_a_reg, in_src_b_reg, in_src_c_reg;
    logic              in_arg_a_needed, in_arg_b_needed, in_arg_c_needed;
    logic              in_acc_needed, in_writes_ch, in_writes_acc;
    logic [3:0]        in_dest;
    logic [CTRL_W-1:0] in_ctrl;
    logic [RF_AW-1:0]  rf_addr_a, rf_addr_b, rf_addr_c;
    logic [DATA_W-1:0] rf_data_a, rf_data_b, rf_data_c;
    logic              wb_valid, wb_ch, wb_acc;
    logic [3:0]        wb_dest;
    logic              out_valid, out_ready;
    logic [BW-1:0]     out_block;
    logic [4:0]        out_operation;
    logic [3:0]        out_dest;
    logic              out_writes_ch, out_writes_acc, out_acc_needed;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_op_a, out_op_b, out_op_c;

    int vectors = 0;
    int miscompares = 0;
    logic [DATA_W-1:0] mem [0:(1<<RF_AW)-1];
    logic [CTRL_W-1:0] ctrl_exp;

    operand_fetch_stage dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
        .in_block(in_block), .in_operation(in_operation),
        .in_src_a(in_src_a), .in_src_b(in_src_b), .in_src_c(in_src_c),
        .in_src_a_reg(in_src_a_reg), .in_src_b_reg(in_src_b_reg), .in_src_c_reg(in_src_c_reg),
        .in_arg_a_needed(in_arg_a_needed), .in_arg_b_needed(in_arg_b_needed),
        .in_arg_c_needed(in_arg_c_needed), .in_acc_needed(in_acc_needed),
        .in_dest(in_dest), .in_writes_ch(in_writes_ch), .in_writes_acc(in_writes_acc),
        .in_ctrl(in_ctrl),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_addr_c(rf_addr_c),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b), .rf_data_c(rf_data_c),
        .wb_valid(wb_valid), .wb_ch(wb_ch), .wb_acc(wb_acc), .wb_dest(wb_dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_block(out_block), .out_operation(out_operation), .out_dest(out_dest),
        .out_writes_ch(out_writes_ch), .out_writes_acc(out_writes_acc), .out_ctrl(out_ctrl),
        .out_acc_needed(out_acc_needed),
        .out_op_a(out_op_a), .out_op_b(out_op_b), .out_op_c(out_op_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rf_data_a <= mem[rf_addr_a];
        rf_data_b <= mem[rf_addr_b];
        rf_data_c <= mem[rf_addr_c];
    end

    // A scoreboard set and a retirement clear of the same bit must never coincide.
    always @(posedge clk) begin
        if (!reset && dut.set_en && wb_valid &&
            ((dut.hold_q.writes_ch && wb_ch && (wb_dest == dut.hold_q.dest)) ||
             (dut.hold_q.writes_acc && wb_acc))) begin
            miscompares++;
            $display("FAIL set_clr_collision: got set+clear same bit, exp never");
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, exp finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_valid = 0; in_block = '0; in_operation = '0;
        in_src_a = '0; in_src_b = '0; in_src_c = '0;
        in_src_a_reg = 0; in_src_b_reg = 0; in_src_c_reg = 0;
        in_arg_a_needed = 0; in_arg_b_needed = 0; in_arg_c_needed = 0;
        in_acc_needed = 0; in_dest = '0; in_writes_ch = 0; in_writes_acc = 0; in_ctrl = '0;
    endtask

    task automatic accept(input string name);
        int n = 0;
        in_valid = 1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_accept: got in_ready=%b, exp 1 within 20 cycles", name, in_ready);
        end
        tick();
        in_valid = 0;
    endtask

    task automatic run_simple(input string name);
        accept(name);
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1; enable = 1; out_ready = 1;
        wb_valid = 0; wb_ch = 0; wb_acc = 0; wb_dest = '0;
        clear_in();
        tick(); tick();
        reset = 0;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        vectors++;
        if (out_op_a !== 16'h0 || out_ctrl !== '0) begin
            miscompares++; $display("FAIL reset_out_data: got op_a=%h ctrl=%h exp 0", out_op_a, out_ctrl);
        end
        vectors++;
        if (rf_addr_a !== '0) begin miscompares++; $display("FAIL reset_rf_addr: got %h exp 0", rf_addr_a); end
        vectors++;
        if (dut.u_sb.ch_pend_q !== 16'h0 || dut.u_sb.acc_pend_q !== 1'b0) begin
            miscompares++; $display("FAIL reset_scoreboard: got %h/%b exp 0/0", dut.u_sb.ch_pend_q, dut.u_sb.acc_pend_q);
        end
    endtask

    task automatic test_add();
        clear_in();
        ctrl_exp = 38'h12_3456_789A;
        in_block = 8'h11; in_operation = 5'h01; in_ctrl = ctrl_exp;
        in_src_a = 4'd3; in_src_b = 4'd4; in_arg_a_needed = 1; in_arg_b_needed = 1;
        accept("add");
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL add_check_state: got ready=%b valid=%b exp 0/0", in_ready, out_valid);
        end
        vectors++;
        if (rf_addr_a !== 10'h003 || rf_addr_b !== 10'h004) begin
            miscompares++; $display("FAIL add_rf_addr: got %h/%h exp 003/004", rf_addr_a, rf_addr_b);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL add_early_valid: got %b exp 0", out_valid); end
        tick();
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL add_latency: got out_valid=%b exp 1", out_valid); end
        vectors++;
        if (out_op_a !== 16'h0100 || out_op_b !== 16'h0200 || out_op_c !== 16'h0000) begin
            miscompares++; $display("FAIL add_operands: got %h %h %h exp 0100 0200 0000", out_op_a, out_op_b, out_op_c);
        end
        vectors++;
        if (out_ctrl !== ctrl_exp || out_block !== 8'h11 || out_operation !== 5'h01) begin
            miscompares++; $display("FAIL add_passthrough: got ctrl=%h blk=%h op=%h exp %h 11 01", out_ctrl, out_block, out_operation, ctrl_exp);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL add_drain: got valid=%b ready=%b exp 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_raw_stall();
        clear_in();
        in_writes_ch = 1; in_dest = 4'd5;
        run_simple("raw_i1");
        clear_in();
        in_src_a = 4'd5; in_arg_a_needed = 1;
        accept("raw_i2");
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                miscompares++; $display("FAIL raw_stall_%0d: got ready=%b valid=%b exp 0/0", i, in_ready, out_valid);
            end
            tick();
        end
        mem[5] = 16'hBEEF;
        wb_valid = 1; wb_ch = 1; wb_dest = 4'd5;
        tick();
        wb_valid = 0; wb_ch = 0;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL raw_clear_cycle: got %b exp 0", out_valid); end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL raw_read_cycle: got %b exp 0", out_valid); end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_op_a !== 16'hBEEF) begin
            miscompares++; $display("FAIL raw_new_value: got valid=%b op_a=%h exp 1 BEEF", out_valid, out_op_a);
        end
        tick();
    endtask

    task automatic test_block_reg();
        for (int ch = 0; ch < 16; ch++) begin
            clear_in();
            in_writes_ch = 1; in_dest = 4'(ch);
            run_simple("fill");
        end
        vectors++;
        if (dut.u_sb.ch_pend_q !== 16'hFFFF) begin
            miscompares++; $display("FAIL blk_fill: got %h exp FFFF", dut.u_sb.ch_pend_q);
        end
        clear_in();
        mem[10'h20F] = 16'h7777;
        in_block = 8'd7; in_src_a = 4'd1; in_src_a_reg = 1; in_arg_a_needed = 1;
        accept("blk");
        vectors++;
        if (rf_addr_a !== 10'h20F) begin miscompares++; $display("FAIL blk_rf_addr: got %h exp 20F", rf_addr_a); end
        tick(); tick();
        vectors++;
        if (out_valid !== 1'b1 || out_op_a !== 16'h7777) begin
            miscompares++; $display("FAIL blk_no_stall: got valid=%b op_a=%h exp 1 7777", out_valid, out_op_a);
        end
        tick();
        wb_valid = 1; wb_ch = 1;
        for (int ch = 0; ch < 16; ch++) begin
            wb_dest = 4'(ch);
            tick();
        end
        wb_valid = 0; wb_ch = 0;
        vectors++;
        if (dut.u_sb.ch_pend_q !== 16'h0) begin
            miscompares++; $display("FAIL blk_clear_all: got %h exp 0", dut.u_sb.ch_pend_q);
        end
    endtask

    task automatic acc_pair(input string name, input logic second_needs_acc);
        clear_in();
        in_writes_acc = 1;
        run_simple(name);
        clear_in();
        in_acc_needed = second_needs_acc; in_writes_acc = !second_needs_acc;
        accept(name);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL %s_stall_%0d: got %b exp 0", name, i, out_valid); end
            tick();
        end
        wb_valid = 1; wb_acc = 1;
        tick();
        wb_valid = 0; wb_acc = 0;
        tick(); tick();
        vectors++;
        if (out_valid !== 1'b1 || out_acc_needed !== second_needs_acc || out_writes_acc !== !second_needs_acc) begin
            miscompares++; $display("FAIL %s_release: got valid=%b accn=%b wacc=%b exp 1 %b %b",
                name, out_valid, out_acc_needed, out_writes_acc, second_needs_acc, !second_needs_acc);
        end
        tick();
    endtask

    task automatic test_acc_hazard();
        acc_pair("acc_raw", 1'b1);
        acc_pair("acc_waw", 1'b0);
        wb_valid = 1; wb_acc = 1;
        tick();
        wb_valid = 0; wb_acc = 0;
        vectors++;
        if (dut.u_sb.acc_pend_q !== 1'b0) begin miscompares++; $display("FAIL acc_final: got %b exp 0", dut.u_sb.acc_pend_q); end
    endtask

    task automatic test_enable_freeze();
        clear_in();
        in_writes_ch = 1; in_dest = 4'd9;
        run_simple("en_i1");
        clear_in();
        in_src_a = 4'd9; in_arg_a_needed = 1;
        accept("en_i2");
        enable = 0;
        mem[9] = 16'h1234;
        wb_valid = 1; wb_ch = 1; wb_dest = 4'd9;
        tick();
        wb_valid = 0; wb_ch = 0;
        vectors++;
        if (dut.u_sb.ch_pend_q[9] !== 1'b0) begin miscompares++; $display("FAIL en_clear_while_off: got %b exp 0", dut.u_sb.ch_pend_q[9]); end
        tick(); tick();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++; $display("FAIL en_frozen: got valid=%b ready=%b exp 0/0", out_valid, in_ready);
        end
        enable = 1;
        tick(); tick();
        vectors++;
        if (out_valid !== 1'b1 || out_op_a !== 16'h1234) begin
            miscompares++; $display("FAIL en_resume: got valid=%b op_a=%h exp 1 1234", out_valid, out_op_a);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        clear_in();
        out_ready = 0;
        ctrl_exp = 38'h2A_5555_0F0F;
        in_src_a = 4'd3; in_arg_a_needed = 1; in_ctrl = ctrl_exp;
        accept("bp_i1");
        tick(); tick();
        in_src_a = 4'd4; in_ctrl = '0; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_op_a !== 16'h0100 || out_ctrl !== ctrl_exp || in_ready !== 1'b0) begin
                miscompares++; $display("FAIL bp_hold_%0d: got valid=%b op_a=%h ctrl=%h ready=%b exp 1 0100 %h 0",
                    i, out_valid, out_op_a, out_ctrl, in_ready, ctrl_exp);
            end
            tick();
        end
        out_ready = 1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b exp 1", in_ready); end
        tick();
        in_valid = 0;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drop: got %b exp 0", out_valid); end
        tick(); tick();
        vectors++;
        if (out_valid !== 1'b1 || out_op_a !== 16'h0200) begin
            miscompares++; $display("FAIL bp_second: got valid=%b op_a=%h exp 1 0200", out_valid, out_op_a);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        clear_in();
        in_writes_ch = 1; in_dest = 4'd2;
        accept("rst_mid");
        tick();
        vectors++;
        if (dut.state_q !== ST_READ || dut.u_sb.ch_pend_q[2] !== 1'b1) begin
            miscompares++; $display("FAIL rst_mid_setup: got state=%0d pend2=%b exp 2 1", dut.state_q, dut.u_sb.ch_pend_q[2]);
        end
        reset = 1;
        tick();
        reset = 0;
        vectors++;
        if (dut.state_q !== ST_IDLE || dut.u_sb.ch_pend_q !== 16'h0 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_clear: got state=%0d pend=%h valid=%b exp 0 0000 0",
                dut.state_q, dut.u_sb.ch_pend_q, out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL rst_mid_after: got valid=%b ready=%b exp 0/1", out_valid, in_ready);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << RF_AW); i++) mem[i] = 16'hA000 | 16'(i);
        mem[3] = 16'h0100;
        mem[4] = 16'h0200;
        test_reset();
        test_add();
        test_raw_stall();
        test_block_reg();
        test_acc_hazard();
        test_enable_freeze();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
